pipelined_csum_addsub: RTL and testbench
========================================

# pipelined_csum_addsub

Pipelined, parametrised successor to the FPU datapath's combinational conditional sum adder. The N-bit operand is split into K-bit blocks, and each block computes both carry-in hypotheses and selects one. The carry chain is cut into registered stages of BPS blocks each, which gives a configurable latency/fmax trade-off. The block adds add/subtract mode, a valid/ready handshake with full backpressure, and registered status flags (carry, signed overflow, zero). It sits between operand alignment and normalisation in the FPU mantissa path.

## Interface
- N, 32: operand/result width; N ≥ 2.
- K, 4: bits per conditional-sum block; 1 ≤ K ≤ N; the last block is N − (NB−1)·K bits when K does not divide N.
- BPS, 2: blocks per pipeline stage; BPS ≥ 1.
- Derived: NB = ceil(N/K); STAGES = ceil(NB/BPS); latency L = STAGES cycles.

- CLOCK_50, in, 1: single clock; all state updates on the rising edge.
- RESET, in, 1: synchronous, active-high reset.
- in_valid, in, 1: input operands valid.
- in_ready, out, 1: pipeline can accept this cycle.
- A, in, N: operand A.
- B, in, N: operand B.
- Cin, in, 1: carry in (ADD) or borrow in (SUB).
- SUB, in, 1: 0 = A+B+Cin; 1 = A−B−Cin.
- out_valid, out, 1: result valid.
- out_ready, in, 1: consumer accepts the result.
- S, out, N: sum/difference, registered.
- Cout, out, 1: carry out of bit N−1; in SUB mode, 1 means no borrow.
- OVF, out, 1: signed two's-complement overflow.
- ZERO, out, 1: asserted when S == 0.

## Operation
- Effective operand: Be = SUB ? ~B : B. Effective carry: ce = SUB ? ~Cin : Cin. The result is A + Be + ce, taken mod 2^N.
- Each block produces sum0/cout0 (carry-in 0) and sum1/cout1 (carry-in 1). The incoming carry selects between them; a ripple of muxes runs through the BPS blocks of a stage.
- Stage j handles blocks j·BPS to min((j+1)·BPS, NB)−1. It registers its selected sums, its carry-out and the not-yet-consumed upper operand bits.
- Lower result bits that are already final are delayed so all N bits of S leave together. The carry registered between stages is the only inter-stage carry path.
- OVF = (A[N−1] == Be[N−1]) && (S[N−1] != A[N−1]).
- Cout is the carry out of the final block.
- ZERO is computed from the final S. It may be registered with S or derived from it in the output stage, but it must be valid whenever out_valid = 1.
- Handshake (global stall, no bubbles squeezed):
  - adv = ~out_valid | out_ready.
  - in_ready = adv & ~RESET.
  - A transfer occurs when in_valid & in_ready.
  - When adv = 1 every stage register loads from its predecessor, and the stage-0 valid bit loads in_valid & in_ready. When adv = 0 all stage registers hold.
- Output hold: while out_valid = 1 and out_ready = 0, S, Cout, OVF and ZERO hold stable.
- Reset: all valid bits, S, Cout, OVF and ZERO clear to 0. All in-flight operations are discarded, including when RESET is asserted mid-stream. The first transfer is possible in the cycle after RESET deasserts.
- A full pipeline with out_ready = 1 and in_valid = 1 accepts one new operation and retires one result in the same cycle. Throughput is 1 per cycle.
- No combinational path from in_valid to out_valid. in_ready depends on out_ready combinationally, which is documented and accepted.

## Timing
- Latency: an operation accepted at edge t appears with out_valid = 1 after edge t+L−1, i.e. in cycle t+L when the pipeline does not stall. Example: N=32, K=4, BPS=2 gives NB=8, STAGES=4, L=4.
- Every stall cycle (adv = 0) adds exactly one cycle to all in-flight operations. Order is preserved.
- BPS ≥ NB collapses to STAGES=1: one register stage, latency 1.
- Critical path: K-bit block add plus BPS mux levels plus the register. No path spans two stages.

## Test plan
- ADD, N=32/K=4/BPS=2: A=0xFFFF_FFFF, B=0x0000_0001, Cin=0 → after 4 cycles S=0, Cout=1, OVF=0, ZERO=1.
- SUB: A=5, B=7, Cin=0, SUB=1 → S=0xFFFF_FFFE, Cout=0, OVF=0. Also A=0x8000_0000, B=1 → S=0x7FFF_FFFF, OVF=1, Cout=1.
- Streaming: 1000 back-to-back random ops with out_ready=1 → one result per cycle, in order, bit-exact against the reference model including Cin, SUB and all flags.
- Backpressure: random out_ready (50%) with continuous in_valid → no loss or duplication, outputs stable while stalled, in_ready = 0 exactly when out_valid & ~out_ready.
- Reset mid-stream: 3 ops in flight, assert RESET for 1 cycle → out_valid=0 and S=0 next cycle, no stale results later, in_ready=1 the cycle after RESET drops.
- Parameter sweep: (N,K,BPS) = (8,3,1), (13,4,5), (64,8,2) with exhaustive or random vectors → correct results; latency equals ceil(ceil(N/K)/BPS).

Source files
------------

// File: rtl/pipelined_csum_addsub.sv
// Pipelined conditional-sum adder/subtractor for the FPU mantissa path.
// K-bit blocks precompute both carry hypotheses; BPS blocks share one registered stage.
module pipelined_csum_addsub #(
  parameter int unsigned N   = 32,
  parameter int unsigned K   = 4,
  parameter int unsigned BPS = 2
) (
  input  logic         CLOCK_50,
  input  logic         RESET,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  input  logic         Cin,
  input  logic         SUB,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] S,
  output logic         Cout,
  output logic         OVF,
  output logic         ZERO
);

  localparam int unsigned NB     = (N + K - 1) / K;
  localparam int unsigned STAGES = (NB + BPS - 1) / BPS;

  logic         v_q  [STAGES];
  logic         v_d  [STAGES];
  logic [N-1:0] a_q  [STAGES];
  logic [N-1:0] a_d  [STAGES];
  logic [N-1:0] b_q  [STAGES];
  logic [N-1:0] b_d  [STAGES];
  logic [N-1:0] s_q  [STAGES];
  logic [N-1:0] s_d  [STAGES];
  logic         c_q  [STAGES];
  logic         c_d  [STAGES];

  logic [N-1:0] a_in [STAGES];
  logic [N-1:0] b_in [STAGES];
  logic [N-1:0] s_in [STAGES];
  logic         c_in [STAGES];

  logic         ovf_q;
  logic         ovf_d;
  logic         zero_q;
  logic         zero_d;
  logic         adv;

  // Global stall: every stage moves only when the output slot is free or being drained
  assign adv      = ~v_q[STAGES-1] | out_ready;
  assign in_ready = adv & ~RESET;

  // Stage inputs: stage 0 takes the ports (B and Cin inverted for SUB), later stages their predecessor
  always_comb begin
    a_in[0] = A;
    b_in[0] = SUB ? ~B : B;
    c_in[0] = Cin ^ SUB;
    s_in[0] = '0;
    v_d[0]  = in_valid & in_ready;
    for (int j = 1; j < STAGES; j++) begin
      a_in[j] = a_q[j-1];
      b_in[j] = b_q[j-1];
      c_in[j] = c_q[j-1];
      s_in[j] = s_q[j-1];
      v_d[j]  = v_q[j-1];
    end
  end

  // Per stage: each block ripples both hypotheses, then the incoming carry muxes one in
  always_comb begin
    logic [N-1:0] ai;
    logic [N-1:0] bi;
    logic [N-1:0] si;
    logic [N-1:0] s0_v;
    logic [N-1:0] s1_v;
    logic [N-1:0] blk_m;
    logic         carry;
    logic         c0;
    logic         c1;

    ai    = '0;
    bi    = '0;
    si    = '0;
    s0_v  = '0;
    s1_v  = '0;
    blk_m = '0;
    carry = 1'b0;
    c0    = 1'b0;
    c1    = 1'b1;
    a_d   = a_in;
    b_d   = b_in;
    s_d   = s_in;
    c_d   = c_in;

    for (int j = 0; j < STAGES; j++) begin
      ai    = a_in[j];
      bi    = b_in[j];
      si    = s_in[j];
      carry = c_in[j];
      s0_v  = '0;
      s1_v  = '0;
      blk_m = '0;
      c0    = 1'b0;
      c1    = 1'b1;
      for (int i = 0; i < N; i++) begin
        if ((i / K) >= j * BPS && (i / K) < (j + 1) * BPS) begin
          if (i % K == 0) begin
            c0 = 1'b0;
            c1 = 1'b1;
          end
          s0_v[i]  = ai[i] ^ bi[i] ^ c0;
          c0       = (ai[i] & bi[i]) | (c0 & (ai[i] ^ bi[i]));
          s1_v[i]  = ai[i] ^ bi[i] ^ c1;
          c1       = (ai[i] & bi[i]) | (c1 & (ai[i] ^ bi[i]));
          blk_m[i] = 1'b1;
          // Block boundary (or the short last block): commit the chosen hypothesis
          if (i % K == K - 1 || i == N - 1) begin
            si    = (si & ~blk_m) | ((carry ? s1_v : s0_v) & blk_m);
            carry = carry ? c1 : c0;
            blk_m = '0;
          end
        end
      end
      a_d[j] = ai;
      b_d[j] = bi;
      s_d[j] = si;
      c_d[j] = carry;
    end

    ovf_d  = (a_in[STAGES-1][N-1] == b_in[STAGES-1][N-1]) &&
             (s_d[STAGES-1][N-1] != a_in[STAGES-1][N-1]);
    zero_d = ~|s_d[STAGES-1];
  end

  // Stage registers; the last stage doubles as the output register
  always_ff @(posedge CLOCK_50) begin
    if (RESET) begin
      for (int j = 0; j < STAGES; j++) begin
        v_q[j] <= 1'b0;
        a_q[j] <= '0;
        b_q[j] <= '0;
        s_q[j] <= '0;
        c_q[j] <= 1'b0;
      end
      ovf_q  <= 1'b0;
      zero_q <= 1'b0;
    end else if (adv) begin
      v_q    <= v_d;
      a_q    <= a_d;
      b_q    <= b_d;
      s_q    <= s_d;
      c_q    <= c_d;
      ovf_q  <= ovf_d;
      zero_q <= zero_d;
    end
  end

  assign out_valid = v_q[STAGES-1];
  assign S         = s_q[STAGES-1];
  assign Cout      = c_q[STAGES-1];
  assign OVF       = ovf_q;
  assign ZERO      = zero_q;

endmodule

// File: tb/tb_pipelined_csum_addsub.sv
// Bench for pipelined_csum_addsub: directed table, streaming, backpressure, reset, and a parameter sweep.
module tb_pipelined_csum_addsub;

  localparam int LAT = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic        rst, in_valid, in_ready, cin, sub, out_valid, out_ready, cout, ovf, zero;
  logic [31:0] a, b, s;

  pipelined_csum_addsub #(.N(32), .K(4), .BPS(2)) u_dut (
    .CLOCK_50 (clk),
    .RESET    (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .A        (a),
    .B        (b),
    .Cin      (cin),
    .SUB      (sub),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .S        (s),
    .Cout     (cout),
    .OVF      (ovf),
    .ZERO     (zero)
  );

  typedef struct packed {
    logic [31:0] s;
    logic        c;
    logic        o;
    logic        z;
  } res_t;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic        cin;
    logic        sub;
    res_t        exp;
  } vec_t;

  vec_t tbl [10];
  res_t sb_q [$];
  int   t_q  [$];
  int   n_run = 0, n_fail = 0, n_acc = 0, n_ret = 0;
  bit   chk_lat = 1'b0;
  bit   stalled_prev = 1'b0;
  res_t drv_exp, prev_out;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  function automatic res_t model(input logic [31:0] a_i, input logic [31:0] b_i,
                                 input logic cin_i, input logic sub_i);
    logic [31:0] be;
    logic [32:0] full;
    res_t        r;
    be   = sub_i ? ~b_i : b_i;
    full = {1'b0, a_i} + {1'b0, be} + 33'(cin_i ^ sub_i);
    r.s  = full[31:0];
    r.c  = full[32];
    r.o  = (a_i[31] == be[31]) && (r.s[31] != a_i[31]);
    r.z  = (r.s == 32'h0);
    return r;
  endfunction

  task automatic drive(input logic v, input logic [31:0] ai, input logic [31:0] bi,
                       input logic ci, input logic si);
    in_valid = v;
    a        = ai;
    b        = bi;
    cin      = ci;
    sub      = si;
    drv_exp  = model(ai, bi, ci, si);
  endtask

  task automatic drive_rand();
    logic [31:0] ai, bi;
    ai = $urandom();
    bi = $urandom();
    if ($urandom_range(0, 7) == 0) ai = 32'hFFFF_FFFF;
    if ($urandom_range(0, 7) == 0) bi = ai;
    drive(1'b1, ai, bi, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
  endtask

  // One cycle: sample between edges, score transfers, then advance to the next negedge
  task automatic step();
    res_t got, e;
    int   t;
    #1;
    got = {s, cout, ovf, zero};
    chk("in_ready_rule", 64'(in_ready), 64'(!(out_valid && !out_ready)));
    if (stalled_prev) begin
      chk("hold_valid", 64'(out_valid), 64'(1));
      chk("hold_outputs", 64'(got), 64'(prev_out));
    end
    if (in_valid && in_ready) begin
      sb_q.push_back(drv_exp);
      t_q.push_back(cyc + 1);
      n_acc++;
    end
    if (out_valid && out_ready) begin
      n_ret++;
      if (sb_q.size() == 0) begin
        n_run++;
        n_fail++;
        $display("FAIL unexpected_output: got S=%h, expected no result (cycle %0d)", s, cyc);
      end else begin
        e = sb_q.pop_front();
        t = t_q.pop_front();
        chk("S", 64'(s), 64'(e.s));
        chk("Cout", 64'(cout), 64'(e.c));
        chk("OVF", 64'(ovf), 64'(e.o));
        chk("ZERO", 64'(zero), 64'(e.z));
        if (chk_lat) chk("latency", 64'(cyc - t), 64'(LAT - 1));
      end
    end
    stalled_prev = out_valid && !out_ready;
    prev_out     = got;
    @(negedge clk);
  endtask

  task automatic wait_empty(input int max);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int k = 0; k < max && sb_q.size() != 0; k++) step();
    chk("drain_pending", 64'(sb_q.size()), 64'(0));
    sb_q.delete();
    t_q.delete();
  endtask

  // Parameter sweep: each config runs its own random stream with a tied-high out_ready
  for (genvar g = 0; g < 3; g++) begin : g_sweep
    localparam int unsigned SN = (g == 0) ? 8 : (g == 1) ? 13 : 64;
    localparam int unsigned SK = (g == 0) ? 3 : (g == 1) ? 4 : 8;
    localparam int unsigned SB = (g == 0) ? 1 : (g == 1) ? 5 : 2;
    localparam int          SL = (g == 0) ? 3 : (g == 1) ? 1 : 4;

    logic          rst_s, iv, ir, ov, ordy, ci, sb, co, of, zr;
    logic [SN-1:0] a_s, b_s, s_s;
    logic [SN+2:0] q_e [$];
    int            q_t [$];
    int            s_run = 0, s_fail = 0;
    bit            done = 1'b0;

    pipelined_csum_addsub #(.N(SN), .K(SK), .BPS(SB)) u_sw (
      .CLOCK_50 (clk),
      .RESET    (rst_s),
      .in_valid (iv),
      .in_ready (ir),
      .A        (a_s),
      .B        (b_s),
      .Cin      (ci),
      .SUB      (sb),
      .out_valid(ov),
      .out_ready(ordy),
      .S        (s_s),
      .Cout     (co),
      .OVF      (of),
      .ZERO     (zr)
    );

    initial begin
      logic [SN-1:0] be;
      logic [SN:0]   full;
      logic [SN+2:0] e, got;
      int            t;
      rst_s = 1'b1;
      iv    = 1'b0;
      ordy  = 1'b1;
      a_s   = '0;
      b_s   = '0;
      ci    = 1'b0;
      sb    = 1'b0;
      repeat (2) @(negedge clk);
      rst_s = 1'b0;
      for (int c = 0; c < 700; c++) begin
        iv  = (c < 600) && ($urandom_range(0, 3) != 0);
        a_s = SN'({$urandom(), $urandom()});
        b_s = SN'({$urandom(), $urandom()});
        ci  = 1'($urandom_range(0, 1));
        sb  = 1'($urandom_range(0, 1));
        if ($urandom_range(0, 7) == 0) a_s = '1;
        if ($urandom_range(0, 7) == 0) b_s = a_s;
        #1;
        if (iv && ir) begin
          be   = sb ? ~b_s : b_s;
          full = {1'b0, a_s} + {1'b0, be} + (SN + 1)'(ci ^ sb);
          q_e.push_back({full[SN-1:0], full[SN],
                         (a_s[SN-1] == be[SN-1]) && (full[SN-1] != a_s[SN-1]),
                         full[SN-1:0] == '0});
          q_t.push_back(cyc + 1);
        end
        if (ov) begin
          got = {s_s, co, of, zr};
          s_run++;
          if (q_e.size() == 0) begin
            s_fail++;
            $display("FAIL sweep%0d_unexpected: got %h, expected no result", g, got);
          end else begin
            e = q_e.pop_front();
            t = q_t.pop_front();
            if (got !== e) begin
              s_fail++;
              $display("FAIL sweep%0d_result N=%0d: got {S,C,O,Z}=%h, expected %h", g, SN, got, e);
            end
            s_run++;
            if (cyc - t != SL - 1) begin
              s_fail++;
              $display("FAIL sweep%0d_latency: got %0d, expected %0d", g, cyc - t + 1, SL);
            end
          end
        end
        @(negedge clk);
      end
      s_run++;
      if (q_e.size() != 0) begin
        s_fail++;
        $display("FAIL sweep%0d_leftover: got %0d pending, expected 0", g, q_e.size());
      end
      done = 1'b1;
    end
  end

  initial begin
    int base_ret, base_acc;
    tbl[0] = {32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b1};
    tbl[1] = {32'h0000_0005, 32'h0000_0007, 1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0};
    tbl[2] = {32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0};
    tbl[3] = {32'h7FFF_FFFF, 32'h0000_0000, 1'b1, 1'b0, 32'h8000_0000, 1'b0, 1'b1, 1'b0};
    tbl[4] = {32'h1234_5678, 32'h8765_4321, 1'b0, 1'b0, 32'h9999_9999, 1'b0, 1'b0, 1'b0};
    tbl[5] = {32'h0000_000A, 32'h0000_0003, 1'b1, 1'b1, 32'h0000_0006, 1'b1, 1'b0, 1'b0};
    tbl[6] = {32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b0, 1'b1, 32'h0000_0000, 1'b1, 1'b0, 1'b1};
    tbl[7] = {32'h00FF_FFFF, 32'h0000_0001, 1'b1, 1'b0, 32'h0100_0001, 1'b0, 1'b0, 1'b0};
    tbl[8] = {32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b1, 1'b1};
    tbl[9] = {32'h0000_0000, 32'h0000_0000, 1'b1, 1'b1, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0};

    rst       = 1'b1;
    out_ready = 1'b1;
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    #1;
    chk("reset_out_valid", 64'(out_valid), 64'(0));
    chk("reset_S", 64'(s), 64'(0));
    chk("reset_Cout", 64'(cout), 64'(0));
    chk("reset_OVF", 64'(ovf), 64'(0));
    chk("reset_ZERO", 64'(zero), 64'(0));
    chk("reset_in_ready", 64'(in_ready), 64'(0));
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("in_ready_after_reset", 64'(in_ready), 64'(1));
    @(negedge clk);

    // Directed vectors, one at a time, with latency checked
    chk_lat = 1'b1;
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, tbl[i].a, tbl[i].b, tbl[i].cin, tbl[i].sub);
      drv_exp = tbl[i].exp;
      step();
      wait_empty(12);
    end

    // Back-to-back streaming: one result per cycle once the pipe has filled
    base_ret = n_ret;
    for (int i = 0; i < 1000; i++) begin
      drive_rand();
      step();
      if (i >= LAT - 1) chk("stream_throughput", 64'(out_valid), 64'(1));
    end
    wait_empty(20);
    chk("stream_count", 64'(n_ret - base_ret), 64'(1000));

    // Random backpressure with continuous input
    chk_lat  = 1'b0;
    base_ret = n_ret;
    base_acc = n_acc;
    for (int i = 0; i < 500; i++) begin
      drive_rand();
      out_ready = 1'($urandom_range(0, 1));
      step();
    end
    wait_empty(20);
    chk("bp_count", 64'(n_ret - base_ret), 64'(n_acc - base_acc));

    // Reset with three operations in flight
    for (int i = 0; i < 3; i++) begin
      drive_rand();
      step();
    end
    in_valid = 1'b0;
    rst      = 1'b1;
    #1;
    chk("in_ready_in_reset", 64'(in_ready), 64'(0));
    @(posedge clk);
    #1;
    chk("reset_mid_out_valid", 64'(out_valid), 64'(0));
    chk("reset_mid_S", 64'(s), 64'(0));
    @(negedge clk);
    rst = 1'b0;
    sb_q.delete();
    t_q.delete();
    stalled_prev = 1'b0;
    #1;
    chk("in_ready_post_reset", 64'(in_ready), 64'(1));
    @(negedge clk);
    base_ret = n_ret;
    repeat (8) step();
    chk("no_stale_results", 64'(n_ret - base_ret), 64'(0));

    chk_lat = 1'b1;
    drive(1'b1, tbl[2].a, tbl[2].b, tbl[2].cin, tbl[2].sub);
    drv_exp = tbl[2].exp;
    step();
    wait_empty(12);

    for (int k = 0; k < 5000; k++) begin
      if (g_sweep[0].done && g_sweep[1].done && g_sweep[2].done) break;
      @(negedge clk);
    end
    chk("sweep_done", 64'(g_sweep[0].done && g_sweep[1].done && g_sweep[2].done), 64'(1));
    n_run  += g_sweep[0].s_run + g_sweep[1].s_run + g_sweep[2].s_run;
    n_fail += g_sweep[0].s_fail + g_sweep[1].s_fail + g_sweep[2].s_fail;

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
